// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / return-address-stack slice:
// next-PC mode encodings and the parameter legality checks.
package pc_pkg;

    typedef enum logic [2:0] {
        PCS_SEQ  = 3'b000,
        PCS_BR   = 3'b001,
        PCS_JR   = 3'b010,
        PCS_J    = 3'b011,
        PCS_CALL = 3'b100,
        PCS_RET  = 3'b101,
        PCS_TRAP = 3'b110,
        PCS_HOLD = 3'b111
    } pcsrc_t;

    localparam int ADDR_W_MIN = 28;
    localparam int ADDR_W_MAX = 64;
    localparam int RAS_DEPTH_MIN = 2;
    localparam int RAS_DEPTH_MAX = 32;

    function automatic bit addr_w_legal(input int w);
        return (w >= ADDR_W_MIN) && (w <= ADDR_W_MAX);
    endfunction

    function automatic bit ras_depth_legal(input int d);
        return (d >= RAS_DEPTH_MIN) && (d <= RAS_DEPTH_MAX) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: the pointer indexes the next free slot and a
// push into a full stack overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_ovf_evt,
    output logic         o_unf_evt
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [PW:0]   r_cnt;

    logic          w_empty_eff;
    logic          w_full_eff;
    logic          w_do_pop;
    logic [PW-1:0] w_base_ptr;
    logic [PW:0]   w_base_cnt;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (PW + 1)'(DEPTH));

    // A flush in the same cycle makes the stack look empty to the push/pop it accompanies.
    assign w_empty_eff = i_flush | o_empty;
    assign w_full_eff  = ~i_flush & o_full;
    assign w_base_ptr  = i_flush ? '0 : r_ptr;
    assign w_base_cnt  = i_flush ? '0 : r_cnt;
    assign w_do_pop    = i_pop & ~w_empty_eff;

    assign o_ovf_evt = i_push & w_full_eff;
    assign o_unf_evt = i_pop & w_empty_eff;
    assign o_rdata   = r_mem[r_ptr - 1'b1];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_ptr <= w_base_ptr + 1'b1;
            if (!w_full_eff) begin
                r_cnt <= w_base_cnt + 1'b1;
            end
        end else if (w_do_pop) begin
            r_ptr <= r_ptr - 1'b1;
            r_cnt <= r_cnt - 1'b1;
        end else if (i_flush) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end
    end

    // NOTE: the entry array has no reset; the count guarantees a stale slot is
    // never returned, so clearing it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_base_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Next-PC generator with call/return stack, trap vector and sticky error flags.
// Define PC_REDIRECT_CNT_EN to build the saturating redirect counter.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC   = 32'h0000_0080
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCWre,
    input  logic [2:0]        PCSrc,
    input  logic [ADDR_W-1:0] Extend,
    input  logic [ADDR_W-1:0] rs,
    input  logic [25:0]       OP,
    input  logic              flush,
    output logic [ADDR_W-1:0] PC0,
    output logic [ADDR_W-1:0] PC4,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf,
    output logic              misalign,
    output logic [31:0]       redirect_cnt
);

    if (!addr_w_legal(ADDR_W) || !ras_depth_legal(RAS_DEPTH)) begin : g_bad_params
        $error("pc_ras_unit: ADDR_W or RAS_DEPTH outside the supported range");
    end

    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] TRAP_VAL  = ADDR_W'(TRAP_PC);

    logic [ADDR_W-1:0] r_pc;
    logic              r_ovf;
    logic              r_unf;
    logic              r_misalign;

    pcsrc_t            w_src;
    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_jr_tgt;
    logic [ADDR_W-1:0] w_j_tgt;
    logic [ADDR_W-1:0] w_nxt;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_evt;
    logic              w_unf_evt;

    assign w_src    = pcsrc_t'(PCSrc);
    assign w_pc4    = r_pc + ADDR_W'(4);
    assign w_br_tgt = w_pc4 + (Extend << 2);
    assign w_jr_tgt = {rs[ADDR_W-1:2], 2'b00};
    // Jump keeps the PC4 bits above the 28-bit region and replaces the rest.
    assign w_j_tgt  = (w_pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({OP, 2'b00});

    assign w_push = PCWre & (w_src == PCS_CALL);
    assign w_pop  = PCWre & (w_src == PCS_RET);

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (flush),
        .i_wdata   (w_pc4),
        .o_rdata   (w_ras_top),
        .o_empty   (ras_empty),
        .o_full    (ras_full),
        .o_ovf_evt (w_ovf_evt),
        .o_unf_evt (w_unf_evt)
    );

    // NOTE: w_nxt gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_nxt = r_pc;
        unique case (w_src)
            PCS_SEQ:  w_nxt = w_pc4;
            PCS_BR:   w_nxt = w_br_tgt;
            PCS_JR:   w_nxt = w_jr_tgt;
            PCS_J:    w_nxt = w_j_tgt;
            PCS_CALL: w_nxt = w_j_tgt;
            PCS_RET:  w_nxt = w_unf_evt ? w_jr_tgt : w_ras_top;
            PCS_TRAP: w_nxt = TRAP_VAL;
            PCS_HOLD: w_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_VAL;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            if (PCWre) begin
                r_pc <= w_nxt;
            end
            if (PCWre && (w_src == PCS_JR) && (rs[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end
            if (w_unf_evt) begin
                r_unf <= 1'b1;
            end
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] r_redirect_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_redirect_cnt <= '0;
        end else if (PCWre && (w_src != PCS_SEQ) && (w_src != PCS_HOLD)
                     && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    assign redirect_cnt = r_redirect_cnt;
`else
    assign redirect_cnt = '0;
`endif

    assign PC0      = r_pc;
    assign PC4      = w_pc4;
    assign ras_ovf  = r_ovf;
    assign ras_unf  = r_unf;
    assign misalign = r_misalign;

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised next-generation program counter for the multicycle CPU.
- Adds call/return through an internal return-address stack (RAS), a trap vector, stack flush, and sticky error flags.
- Sits between the control unit (PCWre, PCSrc) and instruction memory (PC0). It feeds PC4 to the register file and the branch adder path.

Parameters:
- ADDR_W, 32, PC width in bits; legal range 28..64.
- RAS_DEPTH, 4, number of RAS entries; power of two, 2..32.
- RESET_PC, 32'h0000_0000, value loaded into PC0 on reset, zero-extended or truncated to ADDR_W.
- TRAP_PC, 32'h0000_0080, target for trap mode, zero-extended or truncated to ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- PCWre  in  1  PC write enable; 0 freezes PC and RAS.
- PCSrc  in  3  next-PC mode select (encoding below).
- Extend  in  ADDR_W  sign-extended branch offset, in words.
- rs  in  ADDR_W  register jump target.
- OP  in  26  jump instruction index field.
- flush  in  1  clears the RAS.
- PC0  out  ADDR_W  current PC.
- PC4  out  ADDR_W  PC0+4, combinational.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.
- ras_ovf  out  1  sticky: a push occurred while the RAS was full.
- ras_unf  out  1  sticky: a pop occurred while the RAS was empty.
- misalign  out  1  sticky: a register target had bits [1:0] != 0.
- redirect_cnt  out  32  count of non-sequential PC updates (optional feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - PC0=RESET_PC.
  - RAS count=0, stack pointer=0, entries undefined.
  - All sticky flags=0; redirect_cnt=0.
- Reset deassertion is synchronised by the system; the block samples reset only as an async clear.
- Updates occur only on a rising clk edge with PCWre=1. With PCWre=0, PC0, the RAS and the counter hold; flush is still honoured.
- PCSrc modes, where nxt is the value loaded into PC0:
  - 000 SEQ: nxt=PC4.
  - 001 BR: nxt=PC4+(Extend<<2).
  - 010 JR: nxt={rs[ADDR_W-1:2],2'b00}; misalign set if rs[1:0]!=0.
  - 011 J: nxt={PC4[ADDR_W-1:28],OP,2'b00}.
  - 100 CALL: nxt=J target; push PC4.
  - 101 RET: pop the top entry into nxt. If the RAS is empty, nxt=JR target, ras_unf is set, and the count stays 0.
  - 110 TRAP: nxt=TRAP_PC.
  - 111 HOLD: nxt=PC0.
- Arithmetic: all additions are modulo 2^ADDR_W; carry is discarded and wrap-around is silent.
- PC latency: nxt is visible on PC0 one cycle after the sampling edge; PC4 follows combinationally.
- RAS organisation:
  - Circular buffer; the pointer indexes the next free slot.
  - Push writes slot[ptr], then ptr+1.
  - Pop reads slot[ptr-1], then ptr-1. The popped value is used in the same edge's nxt.
- RAS boundaries:
  - Push when full overwrites the oldest entry.
  - After a push when full, count stays RAS_DEPTH and ras_ovf is set.
  - Pointer wraps modulo RAS_DEPTH.
- flush:
  - Sets count=0 at the edge.
  - If flush coincides with a CALL (PCWre=1), the push is applied after the clear: count=1, top=PC4.
  - If flush coincides with a RET, the pop sees an empty RAS: nxt=JR target and ras_unf is set.
- Sticky flags clear only on reset.
- No state machine beyond the PC register and the RAS pointer/count; one operation per cycle by construction.

Optional Feature:
- Macro PC_REDIRECT_CNT_EN.
- Defined: redirect_cnt increments on every PCWre=1 edge with PCSrc in 001..110. It saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: redirect_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Package pc_pkg holds:
  - PCSrc encodings: PCS_SEQ, PCS_BR, PCS_JR, PCS_J, PCS_CALL, PCS_RET, PCS_TRAP, PCS_HOLD.
  - A 3-bit pcsrc_t typedef.
  - The ADDR_W legality check constant.
- One sub-module, pc_ras, handles the stack:
  - Inputs: push, pop, flush, wdata.
  - Outputs: rdata (top), empty, full, ovf_evt, unf_evt.
  - The top level owns the next-PC mux and the sticky flags.

Test Plan:
- Reset then SEQ ×2, PCWre=1, default parameters -> PC0 0x0 → 0x4 → 0x8; PC4=0xC.
- At PC0=0x8: BR with Extend=0x3 -> PC0=0x18. Then J with OP=0x64 -> PC0=0x190.
- At PC0=0x190: CALL with OP=0x100 -> PC0=0x400, ras_empty=0. Then RET -> PC0=0x194, ras_empty=1.
- RAS_DEPTH=4, five CALLs, then five RETs with rs=0x2000:
  - ras_full=1 after the 4th CALL; ras_ovf=1 after the 5th.
  - RETs return pushes 5, 4, 3, 2.
  - 5th RET gives PC0=0x2000 and ras_unf=1.
- PCWre=0 with PCSrc=J -> PC0 unchanged.
- JR with rs=0x1003 -> PC0=0x1000, misalign=1.
- Assert reset mid-cycle between edges -> PC0=RESET_PC immediately, all flags 0; flush together with CALL gives count=1.
